gtp_rx_deframer: RTL and testbench
==================================

// Module: gtp_rx_deframer
// PURPOSE
//  Receive-side link layer on the GTP loopback path, the counterpart of the TX framer.
//  - TX framer sends IDLE while its FIFO is empty and payload words otherwise.
//  - This block hunts for IDLE lock, strips IDLEs and writes payload words into the RX FIFO.
//  - Flags code errors and FIFO overflow; the UART drain side reads the RX FIFO.
// PARAMETERS
//  LOCK_IDLES  4         consecutive IDLE words required to declare link up
//  LOSS_ERRS   3         consecutive bad words in LINKED that drop link
//  IDLE_WORD   16'h50BC  IDLE pattern: K28.5 (low byte), D16.2 (high byte)
//  IDLE_K      2'b01     rxcharisk value accompanying IDLE_WORD
//  CNT_W       32        width of rx_word_cnt
// PORTS
//  gtp_clk      in   1      RX user clock; all logic on rising edge
//  reset        in   1      synchronous, active-low reset
//  rxinit_done  in   1      GTP RX initialisation complete
//  rxdata       in   16     GTP RX parallel data
//  rxcharisk    in   2      per-byte K flag (bit0 = low byte)
//  fifo_full    in   1      RX FIFO full
//  fifo_din     out  16     payload word to RX FIFO
//  fifo_we      out  1      RX FIFO write strobe
//  link_up      out  1      high in LINKED state
//  code_err     out  1      sticky: non-IDLE K word or bad charisk seen while LINKED
//  rx_overflow  out  1      sticky: payload word dropped because fifo_full
//  rx_word_cnt  out  CNT_W  payload words written (wraps)
//  seq_err_cnt  out  16     sequence mismatches (see CONFIGURATION)
// BEHAVIOUR
//  Reset (reset==0 at edge): all outputs 0, state WAIT_INIT, counters cleared.
//  Word classes:
//   - IDLE: rxcharisk==IDLE_K && rxdata==IDLE_WORD.
//   - DATA: rxcharisk==2'b00.
//   - BAD: anything else.
//  States:
//   - WAIT_INIT: go to HUNT when rxinit_done==1.
//   - HUNT: count consecutive IDLE; any non-IDLE clears the count.
//     Count reaching LOCK_IDLES -> LINKED (link_up=1 next cycle).
//     DATA is never written in HUNT.
//   - LINKED:
//     - IDLE dropped.
//     - DATA -> fifo_din=rxdata, fifo_we=1 exactly one cycle after the word is sampled.
//     - BAD -> code_err=1, err run +1; IDLE or DATA clears the run.
//     - Run reaching LOSS_ERRS -> HUNT, link_up=0 next cycle.
//  rxinit_done low in any state -> WAIT_INIT next cycle, link_up=0, no write that cycle.
//  Sticky flags clear only on reset.
//  Overflow: DATA while fifo_full -> fifo_we stays 0, word dropped, rx_overflow=1,
//   rx_word_cnt not incremented.
//  rx_word_cnt: +1 per fifo_we, wraps modulo 2^CNT_W.
//  Reset mid-frame: a pending write is cancelled (fifo_we=0 on the cycle after reset).
// CONFIGURATION
//  RX_SEQ_CHECK_EN defined:
//   - First DATA word after each LINKED entry seeds expected = word+1.
//   - Each later written word is compared with expected (mod 2^16).
//   - Mismatch -> seq_err_cnt +1, saturating at 16'hFFFF, then reseed from the word.
//   - Dropped (overflow) words do not advance expected.
//  RX_SEQ_CHECK_EN undefined: no checker logic, seq_err_cnt tied to 0.
// TESTING
//  1 rxinit_done=1, 4 IDLEs -> link_up=1 on cycle after 4th IDLE; 3 IDLEs + DATA -> stays HUNT.
//  2 LINKED, DATA 0x0001..0x0010 with IDLEs interleaved -> 16 writes in order,
//    rx_word_cnt=16, each fifo_we one cycle after its input.
//  3 LINKED, fifo_full=1 during 0x0005 -> word absent, rx_overflow=1, rx_word_cnt excludes it.
//  4 LINKED, 2 BAD then IDLE -> code_err=1, link stays; 3 consecutive BAD -> link_up=0, HUNT.
//  5 rxinit_done dropped while DATA streaming -> WAIT_INIT next cycle, no further fifo_we;
//    reset=0 pulse -> all outputs 0.
//  6 (RX_SEQ_CHECK_EN) DATA 1,2,3,7,8 -> seq_err_cnt=1;
//    without macro -> seq_err_cnt=0.

Source files
------------

// File: rtl/gtp_rx_deframer.sv
// rtl/gtp_rx_deframer.sv - GTP RX link layer: IDLE lock hunt, IDLE strip, payload write to RX FIFO
//
// Purpose:
//   Hunts for LOCK_IDLES consecutive IDLE words to bring the link up, then strips
//   IDLEs and forwards payload (DATA) words to the RX FIFO one cycle after they are
//   sampled. Code errors and FIFO overflow are reported as sticky flags. A run of
//   LOSS_ERRS consecutive BAD words drops the link back to hunting.
//
// Optional feature macro: RX_SEQ_CHECK_EN
//   When defined, written payload words are checked as an incrementing sequence and
//   mismatches are counted in o_seq_err_cnt. When undefined, o_seq_err_cnt is 0.
//
// Ports:
//   i_gtp_clk      in   1      RX user clock, rising edge
//   i_reset        in   1      synchronous active-low reset
//   i_rxinit_done  in   1      GTP RX initialisation complete
//   i_rxdata       in   16     GTP RX parallel data
//   i_rxcharisk    in   2      per-byte K flag (bit0 = low byte)
//   i_fifo_full    in   1      RX FIFO full
//   o_fifo_din     out  16     payload word to RX FIFO
//   o_fifo_we      out  1      RX FIFO write strobe
//   o_link_up      out  1      high while linked
//   o_code_err     out  1      sticky: BAD word seen while linked
//   o_rx_overflow  out  1      sticky: payload word dropped on full FIFO
//   o_rx_word_cnt  out  CNT_W  payload words written (wraps)
//   o_seq_err_cnt  out  16     sequence mismatches (saturating)

module gtp_rx_deframer #(
  parameter int unsigned LOCK_IDLES = 4,
  parameter int unsigned LOSS_ERRS  = 3,
  parameter logic [15:0] IDLE_WORD  = 16'h50BC,
  parameter logic [1:0]  IDLE_K     = 2'b01,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             i_gtp_clk,
  input  logic             i_reset,
  input  logic             i_rxinit_done,
  input  logic [15:0]      i_rxdata,
  input  logic [1:0]       i_rxcharisk,
  input  logic             i_fifo_full,
  output logic [15:0]      o_fifo_din,
  output logic             o_fifo_we,
  output logic             o_link_up,
  output logic             o_code_err,
  output logic             o_rx_overflow,
  output logic [CNT_W-1:0] o_rx_word_cnt,
  output logic [15:0]      o_seq_err_cnt
);

  localparam int unsigned IDLE_CW = $clog2(LOCK_IDLES + 1);
  localparam int unsigned ERR_CW  = $clog2(LOSS_ERRS + 1);
  localparam logic [IDLE_CW-1:0] LOCK_LAST = IDLE_CW'(LOCK_IDLES - 1);
  localparam logic [ERR_CW-1:0]  LOSS_LAST = ERR_CW'(LOSS_ERRS - 1);

  typedef enum logic [1:0] {
    S_WAIT_INIT = 2'd0,
    S_HUNT      = 2'd1,
    S_LINKED    = 2'd2
  } state_t;

  state_t             r_state;
  logic [IDLE_CW-1:0] r_idle_run;
  logic [ERR_CW-1:0]  r_err_run;
  logic [15:0]        r_fifo_din;
  logic               r_fifo_we;
  logic               r_link_up;
  logic               r_code_err;
  logic               r_rx_overflow;
  logic [CNT_W-1:0]   r_rx_word_cnt;

  logic w_is_idle;
  logic w_is_data;
  logic w_is_bad;
  logic w_write;
  logic w_lock;

  assign w_is_idle = (i_rxcharisk == IDLE_K) && (i_rxdata == IDLE_WORD);
  assign w_is_data = (i_rxcharisk == 2'b00);
  assign w_is_bad  = !w_is_idle && !w_is_data;
  // Payload word accepted into the FIFO on this edge.
  assign w_write   = (r_state == S_LINKED) && i_rxinit_done && w_is_data && !i_fifo_full;
  // Final IDLE of the lock run sampled on this edge.
  assign w_lock    = (r_state == S_HUNT) && i_rxinit_done && w_is_idle && (r_idle_run == LOCK_LAST);

  always_ff @(posedge i_gtp_clk) begin
    if (!i_reset) begin
      r_state       <= S_WAIT_INIT;
      r_idle_run    <= '0;
      r_err_run     <= '0;
      r_fifo_din    <= '0;
      r_fifo_we     <= 1'b0;
      r_link_up     <= 1'b0;
      r_code_err    <= 1'b0;
      r_rx_overflow <= 1'b0;
      r_rx_word_cnt <= '0;
    end else begin
      r_fifo_we <= 1'b0;
      if (!i_rxinit_done) begin
        // Loss of RX init overrides everything, including a DATA word this cycle.
        r_state    <= S_WAIT_INIT;
        r_link_up  <= 1'b0;
        r_idle_run <= '0;
        r_err_run  <= '0;
      end else begin
        case (r_state)
          S_WAIT_INIT: begin
            r_state    <= S_HUNT;
            r_idle_run <= '0;
          end
          S_HUNT: begin
            if (w_lock) begin
              r_state    <= S_LINKED;
              r_link_up  <= 1'b1;
              r_idle_run <= '0;
              r_err_run  <= '0;
            end else if (w_is_idle) begin
              r_idle_run <= r_idle_run + 1'b1;
            end else begin
              r_idle_run <= '0;
            end
          end
          S_LINKED: begin
            if (w_is_bad) begin
              r_code_err <= 1'b1;
              if (r_err_run == LOSS_LAST) begin
                r_state    <= S_HUNT;
                r_link_up  <= 1'b0;
                r_err_run  <= '0;
                r_idle_run <= '0;
              end else begin
                r_err_run <= r_err_run + 1'b1;
              end
            end else begin
              r_err_run <= '0;
              if (w_write) begin
                r_fifo_we     <= 1'b1;
                r_fifo_din    <= i_rxdata;
                r_rx_word_cnt <= r_rx_word_cnt + 1'b1;
              end else if (w_is_data) begin
                r_rx_overflow <= 1'b1;
              end
            end
          end
          default: begin
            r_state   <= S_WAIT_INIT;
            r_link_up <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef RX_SEQ_CHECK_EN
  logic        r_seq_seeded;
  logic [15:0] r_seq_exp;
  logic [15:0] r_seq_err_cnt;

  // Only words actually written take part; dropped words neither seed nor advance.
  always_ff @(posedge i_gtp_clk) begin
    if (!i_reset) begin
      r_seq_seeded  <= 1'b0;
      r_seq_exp     <= '0;
      r_seq_err_cnt <= '0;
    end else if (w_lock) begin
      r_seq_seeded <= 1'b0;
    end else if (w_write) begin
      if (r_seq_seeded && (i_rxdata != r_seq_exp) && (r_seq_err_cnt != 16'hFFFF)) begin
        r_seq_err_cnt <= r_seq_err_cnt + 16'd1;
      end
      r_seq_exp    <= i_rxdata + 16'd1;
      r_seq_seeded <= 1'b1;
    end
  end

  assign o_seq_err_cnt = r_seq_err_cnt;
`else
  assign o_seq_err_cnt = '0;
`endif

  assign o_fifo_din    = r_fifo_din;
  assign o_fifo_we     = r_fifo_we;
  assign o_link_up     = r_link_up;
  assign o_code_err    = r_code_err;
  assign o_rx_overflow = r_rx_overflow;
  assign o_rx_word_cnt = r_rx_word_cnt;

endmodule

// File: tb/tb_gtp_rx_deframer.sv
// tb/tb_gtp_rx_deframer.sv - self-checking bench for gtp_rx_deframer
`timescale 1ns/1ps

module tb_gtp_rx_deframer;

  localparam logic [15:0] IDLE_W = 16'h50BC;
  localparam int LOCK = 4;
  localparam int LOSS = 3;
`ifdef RX_SEQ_CHECK_EN
  localparam int SEQ_EN = 1;
`else
  localparam int SEQ_EN = 0;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        init  = 1'b0;
  logic        full  = 1'b0;
  logic [15:0] rxd   = 16'h0;
  logic [1:0]  rxk   = 2'b00;

  logic [15:0] din;
  logic        we;
  logic        link;
  logic        cerr;
  logic        ovf;
  logic [31:0] cnt;
  logic [15:0] seq;

  always #5 clk = ~clk;

  gtp_rx_deframer dut (
    .i_gtp_clk     (clk),
    .i_reset       (rst_n),
    .i_rxinit_done (init),
    .i_rxdata      (rxd),
    .i_rxcharisk   (rxk),
    .i_fifo_full   (full),
    .o_fifo_din    (din),
    .o_fifo_we     (we),
    .o_link_up     (link),
    .o_code_err    (cerr),
    .o_rx_overflow (ovf),
    .o_rx_word_cnt (cnt),
    .o_seq_err_cnt (seq)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 = waiting for init, 1 = hunting, 2 = linked.
  int          m_mode = 0;
  int          m_idles = 0;
  int          m_errs = 0;
  bit          m_valid = 0;
  bit          m_link = 0;
  bit          m_we = 0;
  bit          m_cerr = 0;
  bit          m_ovf = 0;
  bit          m_seeded = 0;
  bit          is_idle;
  bit          is_data;
  logic [15:0] m_din = 16'h0;
  logic [15:0] m_last = 16'h0;
  logic [15:0] m_seq = 16'h0;
  logic [31:0] m_cnt = 32'h0;

  always @(posedge clk) begin
    is_idle = (rxk == 2'b01) && (rxd == IDLE_W);
    is_data = (rxk == 2'b00);
    m_we = 0;
    if (!rst_n) begin
      m_valid = 1; m_mode = 0; m_idles = 0; m_errs = 0; m_link = 0;
      m_cerr = 0; m_ovf = 0; m_din = 0; m_cnt = 0; m_seq = 0; m_seeded = 0;
    end else if (!init) begin
      m_mode = 0;
      m_link = 0;
    end else begin
      case (m_mode)
        0: begin m_mode = 1; m_idles = 0; end
        1: begin
          m_idles = is_idle ? m_idles + 1 : 0;
          if (m_idles == LOCK) begin
            m_mode = 2; m_link = 1; m_errs = 0; m_seeded = 0;
          end
        end
        default: begin
          if (!is_idle && !is_data) begin
            m_cerr = 1;
            m_errs++;
            if (m_errs == LOSS) begin m_mode = 1; m_link = 0; m_idles = 0; end
          end else begin
            m_errs = 0;
            if (is_data) begin
              if (full) m_ovf = 1;
              else begin
                m_we = 1; m_din = rxd; m_cnt++;
                if (SEQ_EN != 0) begin
                  if (m_seeded && rxd != 16'(m_last + 16'd1) && m_seq != 16'hFFFF) m_seq++;
                  m_seeded = 1;
                  m_last = rxd;
                end
              end
            end
          end
        end
      endcase
    end
  end

  // Per-cycle compare on the falling edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("cmp_link_up", 32'(link), 32'(m_link));
      check("cmp_fifo_we", 32'(we), 32'(m_we));
      if (m_we) check("cmp_fifo_din", 32'(din), 32'(m_din));
      check("cmp_code_err", 32'(cerr), 32'(m_cerr));
      check("cmp_rx_overflow", 32'(ovf), 32'(m_ovf));
      check("cmp_rx_word_cnt", cnt, m_cnt);
      check("cmp_seq_err_cnt", 32'(seq), 32'(m_seq));
    end
  end

  task automatic cyc(input logic r, input logic in, input logic [15:0] d, input logic [1:0] k, input logic f);
    rst_n = r; init = in; rxd = d; rxk = k; full = f;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b1, 1'b1, IDLE_W, 2'b01, 1'b0);
  endtask

  task automatic data(input logic [15:0] d, input logic f);
    cyc(1'b1, 1'b1, d, 2'b00, f);
  endtask

  task automatic bad();
    cyc(1'b1, 1'b1, 16'h1234, 2'b10, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_link"}, 32'(link), 0);
    check({tag, "_we"}, 32'(we), 0);
    check({tag, "_din"}, 32'(din), 0);
    check({tag, "_cerr"}, 32'(cerr), 0);
    check({tag, "_ovf"}, 32'(ovf), 0);
    check({tag, "_cnt"}, cnt, 0);
    check({tag, "_seq"}, 32'(seq), 0);
  endtask

  int          rnd;
  logic [15:0] seqw;

  initial begin
    // Reset
    cyc(1'b0, 1'b0, 16'h0, 2'b00, 1'b0);
    cyc(1'b0, 1'b0, 16'h0, 2'b00, 1'b0);
    check_all_zero("reset");

    // Lock hunt: 3 IDLEs + DATA must not lock, 4 IDLEs must
    idle();
    check("wait_to_hunt_link", 32'(link), 0);
    idle(); idle(); idle();
    data(16'hAAAA, 1'b0);
    check("hunt_3idle_data_link", 32'(link), 0);
    check("hunt_no_write", 32'(we), 0);
    idle(); idle(); idle();
    check("hunt_3idle_link", 32'(link), 0);
    idle();
    check("lock_4th_idle_link", 32'(link), 1);
    check("model_lock", 32'(m_link), 1);

    // DATA 1..16 interleaved with IDLEs
    for (int i = 1; i <= 16; i++) begin
      data(16'(i), 1'b0);
      check("data_we", 32'(we), 1);
      check("data_din", 32'(din), 32'(i));
      idle();
      check("idle_strip_we", 32'(we), 0);
    end
    check("cnt_16", cnt, 16);
    check("model_cnt_16", m_cnt, 16);
    check("seq_after_16", 32'(seq), 0);

    // Overflow on 0x0012
    data(16'h0011, 1'b0);
    data(16'h0012, 1'b1);
    check("ovf_we", 32'(we), 0);
    check("ovf_flag", 32'(ovf), 1);
    check("ovf_cnt", cnt, 17);
    data(16'h0013, 1'b0);
    check("after_ovf_din", 32'(din), 32'h13);
    check("after_ovf_cnt", cnt, 18);
    check("after_ovf_seq", 32'(seq), 32'(SEQ_EN));

    // BAD runs
    bad(); bad();
    check("bad2_cerr", 32'(cerr), 1);
    check("bad2_link", 32'(link), 1);
    idle();
    bad(); bad();
    check("bad2_again_link", 32'(link), 1);
    bad();
    check("loss_3bad_link", 32'(link), 0);

    // Relock, then drop init while streaming
    idle(); idle(); idle(); idle();
    check("relock_link", 32'(link), 1);
    data(16'h0100, 1'b0);
    check("relock_data_we", 32'(we), 1);
    cyc(1'b1, 1'b0, 16'h0101, 2'b00, 1'b0);
    check("init_drop_we", 32'(we), 0);
    check("init_drop_link", 32'(link), 0);
    cyc(1'b1, 1'b0, 16'h0102, 2'b00, 1'b0);
    check("init_low_we", 32'(we), 0);
    check("init_low_cnt", cnt, 19);

    // Reset with a write pending
    idle(); idle(); idle(); idle(); idle();
    data(16'h0200, 1'b0);
    check("pre_reset_we", 32'(we), 1);
    cyc(1'b0, 1'b1, 16'h0201, 2'b00, 1'b0);
    check_all_zero("midreset");

    // Sequence checker: 1,2,3,7,8
    idle(); idle(); idle(); idle(); idle();
    check("seq_lock", 32'(link), 1);
    data(16'd1, 1'b0); data(16'd2, 1'b0); data(16'd3, 1'b0);
    data(16'd7, 1'b0); data(16'd8, 1'b0);
    check("seq_12378", 32'(seq), 32'(SEQ_EN));
    check("seq_cnt", cnt, 5);

    // Randomised phase, checked by the model compare process
    seqw = 16'h0;
    for (int n = 0; n < 4000; n++) begin
      logic r_rst;
      logic r_init;
      logic r_full;
      r_rst  = ($urandom_range(0, 399) != 0);
      r_init = ($urandom_range(0, 79) != 0);
      r_full = ($urandom_range(0, 9) == 0);
      rnd    = $urandom_range(0, 99);
      if (!m_link && rnd < 85) begin
        cyc(r_rst, r_init, IDLE_W, 2'b01, r_full);
      end else if (rnd < 40) begin
        cyc(r_rst, r_init, IDLE_W, 2'b01, r_full);
      end else if (rnd < 85) begin
        if ($urandom_range(0, 9) == 0) seqw = 16'($urandom);
        cyc(r_rst, r_init, seqw, 2'b00, r_full);
        seqw = seqw + 16'd1;
      end else if (rnd < 95) begin
        cyc(r_rst, r_init, 16'($urandom), 2'b01 + 2'($urandom_range(0, 2)), r_full);
      end else begin
        cyc(r_rst, r_init, IDLE_W, 2'b11, r_full);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
